// File: rtl/dp_pkg.sv
// Shared definitions for the parametrised accumulator datapath:
// A-source select encodings, default widths and a width sanity check.
package dp_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 5;
    localparam int OP_W_DEF   = 3;

    // Source selected into the accumulator when Aload is asserted
    typedef enum logic [1:0] {
        ASEL_ALU = 2'b00,   // add/sub result (optionally saturated)
        ASEL_IN  = 2'b01,   // external operand
        ASEL_MEM = 2'b10,   // registered RAM read data
        ASEL_SHR = 2'b11    // arithmetic shift right by one
    } asel_e;

    // The instruction word must hold an opcode field above an address field
    function automatic bit widths_ok(input int data_w, input int op_w, input int addr_w);
        return (op_w > 0) && (addr_w > 0) && (data_w >= op_w + addr_w);
    endfunction

endpackage

// File: rtl/dp_ram.sv
// Single-port RAM, DATA_W x 2**ADDR_W, synchronous read-first.
// A write cycle leaves the read register holding its previous value and
// clears the read-valid strobe; the array itself is never reset.
module dp_ram #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rd_valid_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata_q;
    logic              rd_valid_q;

    // Read/write port; the reset branch only clears the read side, and keeping
    // the write inside the else arm is what suppresses writes during reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= ~we_i;
            if (we_i) begin
                mem[addr_i] <= wdata_i;
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o    = rdata_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/accum_datapath_p.sv
// Parametrised accumulator datapath: PC, IR, accumulator A, single-port RAM,
// add/sub ALU with registered signed-overflow flag, and A status flags.
// Sequenced cycle-by-cycle by an external control FSM.
// Optional build macro DATAPATH_SAT_EN: clamp ALU results on signed overflow
// instead of wrapping (Ovf is reported the same way in both builds).
module accum_datapath_p
    import dp_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int OP_W   = OP_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              PCload,
    input  logic              JMPmux,
    input  logic              IRload,
    input  logic              Meminst,
    input  logic              MemWr,
    input  logic              Aload,
    input  logic              Sub,
    input  logic [1:0]        Asel,
    input  logic [DATA_W-1:0] data_in,
    output logic              Aeq0,
    output logic              Apos,
    output logic              Ovf,
    output logic [OP_W-1:0]   IR,
    output logic [ADDR_W-1:0] pc_out,
    output logic              rd_valid,
    output logic [DATA_W-1:0] data_out
);

    localparam int MSB = DATA_W - 1;
    localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    // Refuse to elaborate an instruction word too narrow for opcode + address
    if (!widths_ok(DATA_W, OP_W, ADDR_W)) begin : g_bad_widths
        $error("accum_datapath_p: DATA_W must be >= OP_W + ADDR_W");
    end

    logic [ADDR_W-1:0] pc_q,  pc_d;
    logic [DATA_W-1:0] ir_q,  ir_d;
    logic [DATA_W-1:0] a_q,   a_d;
    logic              ovf_q, ovf_d;

    logic [DATA_W-1:0] mem_q;
    logic [ADDR_W-1:0] mem_addr;
    logic [ADDR_W-1:0] ir_addr;

    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_wrap;
    logic [DATA_W-1:0] alu_res;
    logic              alu_ovf;
    asel_e             asel;

    assign ir_addr  = ir_q[ADDR_W-1:0];
    assign mem_addr = Meminst ? pc_q : ir_addr;
    assign asel     = asel_e'(Asel);

    dp_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .we_i       (MemWr),
        .addr_i     (mem_addr),
        .wdata_i    (a_q),
        .rdata_o    (mem_q),
        .rd_valid_o (rd_valid)
    );

    // ALU: subtract as A + ~mem_q + 1; overflow when the result sign disagrees
    // with the sign the operands force (same signs for add, opposite for sub).
    always_comb begin
        alu_b    = Sub ? ~mem_q : mem_q;
        alu_wrap = a_q + alu_b + {{(DATA_W-1){1'b0}}, Sub};
        alu_ovf  = (a_q[MSB] == alu_b[MSB]) && (alu_wrap[MSB] != a_q[MSB]);
`ifdef DATAPATH_SAT_EN
        // Overflow direction follows A's sign: non-negative A can only overflow upward
        if (alu_ovf) begin
            alu_res = a_q[MSB] ? NEG_MIN : POS_MAX;
        end else begin
            alu_res = alu_wrap;
        end
`else
        alu_res = alu_wrap;
`endif
    end

    // Accumulator source mux; Ovf only tracks ALU loads
    always_comb begin
        a_d   = a_q;
        ovf_d = ovf_q;
        if (Aload) begin
            case (asel)
                ASEL_ALU: begin
                    a_d   = alu_res;
                    ovf_d = alu_ovf;
                end
                ASEL_IN:  a_d = data_in;
                ASEL_MEM: a_d = mem_q;
                ASEL_SHR: a_d = {a_q[MSB], a_q[MSB:1]};
                default:  a_d = a_q;
            endcase
        end
    end

    // PC jump target comes from the IR held before this edge; increment wraps
    always_comb begin
        pc_d = pc_q;
        if (PCload) begin
            pc_d = JMPmux ? ir_addr : pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
    end

    // IR captures the whole RAM word
    always_comb begin
        ir_d = IRload ? mem_q : ir_q;
    end

    // Architectural registers
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_q  <= '0;
            ir_q  <= '0;
            a_q   <= '0;
            ovf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            a_q   <= a_d;
            ovf_q <= ovf_d;
        end
    end

    assign Aeq0     = (a_q == '0);
    assign Apos     = ~a_q[MSB];
    assign Ovf      = ovf_q;
    assign IR       = ir_q[DATA_W-1 -: OP_W];
    assign pc_out   = pc_q;
    assign data_out = a_q;

endmodule

// File: tb/tb_accum_datapath_p.sv
// Directed bench for accum_datapath_p (default widths 8/5/3).
// A behavioural model tracks the architectural state with integer arithmetic;
// one process compares every output against it each cycle, and literal checks
// pin the model at the hand-worked points.
module tb_accum_datapath_p;

    localparam int DW = 8;
    localparam int AW = 5;
    localparam int OW = 3;
    localparam int DEPTH = 32;

    logic          Clock = 1'b0;
    logic          Reset = 1'b0;
    logic          PCload = 0, JMPmux = 0, IRload = 0, Meminst = 0, MemWr = 0, Aload = 0, Sub = 0;
    logic [1:0]    Asel = 2'b00;
    logic [DW-1:0] data_in = '0;
    logic          Aeq0, Apos, Ovf, rd_valid;
    logic [OW-1:0] IR;
    logic [AW-1:0] pc_out;
    logic [DW-1:0] data_out;

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 0;

    accum_datapath_p #(.DATA_W(DW), .ADDR_W(AW), .OP_W(OW)) dut (
        .Clock(Clock), .Reset(Reset), .PCload(PCload), .JMPmux(JMPmux),
        .IRload(IRload), .Meminst(Meminst), .MemWr(MemWr), .Aload(Aload),
        .Sub(Sub), .Asel(Asel), .data_in(data_in), .Aeq0(Aeq0), .Apos(Apos),
        .Ovf(Ovf), .IR(IR), .pc_out(pc_out), .rd_valid(rd_valid), .data_out(data_out)
    );

    initial forever #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_a, m_pc, m_ir, m_q, m_rdv, m_ovf;
    int m_mem [DEPTH];

    function automatic int sgn(input int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    initial forever begin
        @(posedge Clock or posedge Reset);
        if (Reset) begin
            m_a = 0; m_pc = 0; m_ir = 0; m_q = 0; m_rdv = 0; m_ovf = 0;
        end else begin
            int addr, na, npc, nir, nq, novf, r;
            addr = Meminst ? m_pc : (m_ir % DEPTH);
            nq   = MemWr ? m_q : m_mem[addr];
            if (MemWr) m_mem[addr] = m_a;
            npc  = PCload ? (JMPmux ? (m_ir % DEPTH) : (m_pc + 1) % DEPTH) : m_pc;
            nir  = IRload ? m_q : m_ir;
            na   = m_a;
            novf = m_ovf;
            if (Aload) begin
                case (Asel)
                    2'b00: begin
                        r    = Sub ? sgn(m_a) - sgn(m_q) : sgn(m_a) + sgn(m_q);
                        novf = (r > 127 || r < -128) ? 1 : 0;
`ifdef DATAPATH_SAT_EN
                        if (r > 127)  r = 127;
                        if (r < -128) r = -128;
`endif
                        na = r & 255;
                    end
                    2'b01: na = int'(data_in);
                    2'b10: na = m_q;
                    default: na = (sgn(m_a) >>> 1) & 255;
                endcase
            end
            m_rdv = MemWr ? 0 : 1;
            m_a = na; m_pc = npc; m_ir = nir; m_q = nq; m_ovf = novf;
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge Clock);
        if (started) begin
            chk("m.data_out", 32'(data_out), 32'(m_a));
            chk("m.pc_out",   32'(pc_out),   32'(m_pc));
            chk("m.IR",       32'(IR),       32'(m_ir >> 5));
            chk("m.Aeq0",     32'(Aeq0),     32'(m_a == 0));
            chk("m.Apos",     32'(Apos),     32'(m_a < 128));
            chk("m.Ovf",      32'(Ovf),      32'(m_ovf));
            chk("m.rd_valid", 32'(rd_valid), 32'(m_rdv));
        end
    end

    // ---------------- stimulus helpers ----------------
    // ctl = {PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub}
    task automatic step(input logic [6:0] ctl, input logic [1:0] as, input logic [7:0] din);
        {PCload, JMPmux, IRload, Meminst, MemWr, Aload, Sub} = ctl;
        Asel    = as;
        data_in = din;
        @(negedge Clock);
        #1;
    endtask

    task automatic load_a(input logic [7:0] v);  step(7'b0001010, 2'b01, v); endtask
    task automatic wr_pc();                      step(7'b0001100, 2'b00, 8'h00); endtask
    task automatic rd_pc();                      step(7'b0001000, 2'b00, 8'h00); endtask
    task automatic inc_pc();                     step(7'b1001000, 2'b00, 8'h00); endtask
    task automatic alu(input logic sb);          step({6'b000101, sb}, 2'b00, 8'h00); endtask
    task automatic shr();                        step(7'b0001010, 2'b11, 8'h00); endtask

    initial begin
        #1 Reset = 1'b1;
        started = 1;
        @(negedge Clock); #1;
        chk("rst.data_out", 32'(data_out), 0);
        chk("rst.Aeq0", 32'(Aeq0), 1);
        chk("rst.Apos", 32'(Apos), 1);
        chk("rst.pc_out", 32'(pc_out), 0);
        chk("rst.IR", 32'(IR), 0);
        Reset = 1'b0;

        // Fill RAM[i] = i*37+11 using write+increment in one cycle; PC wraps back to 0
        for (int i = 0; i < DEPTH; i++) begin
            load_a(8'((i * 37 + 11) & 255));
            step(7'b1001100, 2'b00, 8'h00);
        end
        chk("init.pc_wrap", 32'(pc_out), 0);

        // Write 80 at PC=0, read it back, 75 - 80
        load_a(8'd80);
        wr_pc();
        chk("wr.rd_valid", 32'(rd_valid), 0);
        rd_pc();
        chk("rd.rd_valid", 32'(rd_valid), 1);
        load_a(8'd75);
        alu(1'b1);
        chk("sub.A", 32'(data_out), 32'hFB);
        chk("sub.Apos", 32'(Apos), 0);
        chk("sub.Aeq0", 32'(Aeq0), 0);
        chk("sub.Ovf", 32'(Ovf), 0);

        // Arithmetic shift right
        shr();
        chk("shr.-5", 32'(data_out), 32'hFD);
        load_a(8'hFF);
        shr();
        chk("shr.-1", 32'(data_out), 32'hFF);

        // 100 + 100 overflows
        load_a(8'd100);
        wr_pc();
        rd_pc();
        alu(1'b0);
`ifdef DATAPATH_SAT_EN
        chk("add.ovf.A", 32'(data_out), 127);
`else
        chk("add.ovf.A", 32'(data_out), 32'hC8);
`endif
        chk("add.ovf.Ovf", 32'(Ovf), 1);
        load_a(8'd5);
        chk("ovf.hold", 32'(Ovf), 1);

        // 1 - (-128) overflows in the other direction of subtraction
        load_a(8'h80);
        wr_pc();
        rd_pc();
        load_a(8'd1);
        alu(1'b1);
`ifdef DATAPATH_SAT_EN
        chk("sub.ovf.A", 32'(data_out), 127);
`else
        chk("sub.ovf.A", 32'(data_out), 32'h81);
`endif
        chk("sub.ovf.Ovf", 32'(Ovf), 1);

        // IR load 0x3B, jump to 27, increment to 31 then wrap
        load_a(8'h3B);
        wr_pc();
        rd_pc();
        step(7'b0011000, 2'b00, 8'h00);
        chk("ir.op", 32'(IR), 1);
        step(7'b1101000, 2'b00, 8'h00);
        chk("jmp.pc", 32'(pc_out), 27);
        for (int i = 0; i < 4; i++) inc_pc();
        chk("inc.pc31", 32'(pc_out), 31);
        inc_pc();
        chk("inc.wrap", 32'(pc_out), 0);

        // IRload with jump in the same cycle: jump uses the old address field
        load_a(8'h45);
        wr_pc();
        rd_pc();
        step(7'b1111000, 2'b00, 8'h00);
        chk("irjmp.pc", 32'(pc_out), 27);
        chk("irjmp.IR", 32'(IR), 2);

        // Read-first at IR address 5 (initial contents 5*37+11 = 196)
        step(7'b0000000, 2'b00, 8'h00);
        step(7'b0000010, 2'b01, 8'h11);
        step(7'b0000100, 2'b00, 8'h00);
        chk("rf.rd_valid", 32'(rd_valid), 0);
        step(7'b0000010, 2'b10, 8'h00);
        chk("rf.old", 32'(data_out), 196);
        step(7'b0000010, 2'b10, 8'h00);
        chk("rf.new", 32'(data_out), 32'h11);

        // Reset mid-run with A=37, PC=9; a write attempted during reset is dropped
        load_a(8'd37);
        step(7'b1100000, 2'b00, 8'h00);
        for (int i = 0; i < 4; i++) inc_pc();
        chk("pre.A", 32'(data_out), 37);
        chk("pre.pc", 32'(pc_out), 9);
        Reset = 1'b1;
        step(7'b0001100, 2'b00, 8'h00);
        chk("mrst.A", 32'(data_out), 0);
        chk("mrst.pc", 32'(pc_out), 0);
        chk("mrst.Aeq0", 32'(Aeq0), 1);
        chk("mrst.Apos", 32'(Apos), 1);
        chk("mrst.Ovf", 32'(Ovf), 0);
        chk("mrst.rd_valid", 32'(rd_valid), 0);
        Reset = 1'b0;
        rd_pc();
        step(7'b0001010, 2'b10, 8'h00);
        chk("mrst.ram_kept", 32'(data_out), 32'h45);

        rd_pc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
